// File: rtl/fifo_rd_64_to_128.sv
// Reader-side width converter: pops two 64-bit FIFO words and presents them as one
// 128-bit word (first word in the upper half) behind a rdy/pull handshake.
module fifo_rd_64_to_128 #(
   parameter int I_W_WIDTH = 64,
   parameter int O_W_WIDTH = 128
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [I_W_WIDTH-1:0] idata,
   input  logic                 not_empty,
   output logic                 o_pop,
   output logic [O_W_WIDTH-1:0] odata,
   output logic                 rdy,
   input  logic                 i_pull
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HI_WAIT = 3'd1,
      S_HI_CAP  = 3'd2,
      S_LO_REQ  = 3'd3,
      S_LO_WAIT = 3'd4,
      S_LO_CAP  = 3'd5,
      S_READY   = 3'd6
   } state_t;

   state_t               state, state_next;
   logic                 o_pop_next, rdy_next;
   logic [I_W_WIDTH-1:0] hi;

   // NOTE: every variable gets a default before the case so no path leaves one
   // unassigned; that is what keeps this block from inferring latches.
   always_comb begin
      state_next = state;
      o_pop_next = 1'b0;
      rdy_next   = 1'b0;
      case (state)
         S_IDLE: begin
            if (not_empty) begin
               o_pop_next = 1'b1;
               state_next = S_HI_WAIT;
            end
         end
         S_HI_WAIT: state_next = S_HI_CAP;
         S_HI_CAP:  state_next = S_LO_REQ;
         // not_empty lags a pop by one cycle, so it is only trusted in the request states.
         S_LO_REQ: begin
            if (not_empty) begin
               o_pop_next = 1'b1;
               state_next = S_LO_WAIT;
            end
         end
         S_LO_WAIT: state_next = S_LO_CAP;
         S_LO_CAP: begin
            rdy_next   = 1'b1;
            state_next = S_READY;
         end
         S_READY: begin
            if (i_pull) begin
               state_next = S_IDLE;
            end else begin
               rdy_next = 1'b1;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values, independent of the order the simulator evaluates blocks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         o_pop <= 1'b0;
         rdy   <= 1'b0;
         hi    <= '0;
         odata <= '0;
      end else begin
         state <= state_next;
         o_pop <= o_pop_next;
         rdy   <= rdy_next;
         if (state == S_HI_CAP) begin
            hi <= idata;
         end
         if (state == S_LO_CAP) begin
            odata <= {hi, idata};
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_64_to_128.sv
// Directed bench for fifo_rd_64_to_128: a queue models the 64-bit FIFO and returns
// popped data in the cycle after o_pop; expected words are written out by hand.
module tb_fifo_rd_64_to_128;

   logic         clk = 1'b0;
   logic         reset;
   logic [63:0]  idata;
   logic         not_empty;
   logic         o_pop;
   logic [127:0] odata;
   logic         rdy;
   logic         i_pull;

   int           n_vec = 0;
   int           n_err = 0;
   logic [63:0]  fifo_q[$];
   int           pop_cnt   = 0;
   int           adj_cnt   = 0;
   int           under_cnt = 0;
   logic         prev_pop  = 1'b0;

   always #5 clk = ~clk;

   fifo_rd_64_to_128 #(.I_W_WIDTH(64), .O_W_WIDTH(128)) dut (
      .clk       (clk),
      .reset     (reset),
      .idata     (idata),
      .not_empty (not_empty),
      .o_pop     (o_pop),
      .odata     (odata),
      .rdy       (rdy),
      .i_pull    (i_pull)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; advances one clock and returns at the next negedge.
   task automatic step();
      logic pop_now;
      pop_now = o_pop;
      if (pop_now && prev_pop) adj_cnt++;
      prev_pop = pop_now;
      @(posedge clk);
      #1;
      if (pop_now) begin
         pop_cnt++;
         if (fifo_q.size() == 0) under_cnt++;
         else idata = fifo_q.pop_front();
      end
      not_empty = (fifo_q.size() != 0);
      @(negedge clk);
   endtask

   task automatic push(input logic [63:0] w);
      fifo_q.push_back(w);
      not_empty = 1'b1;
   endtask

   task automatic wait_rdy(input string tag, output int n);
      n = 0;
      while (!rdy && n < 40) begin
         step();
         n++;
      end
      check({tag, "_rdy_seen"}, {127'd0, rdy}, 128'd1);
   endtask

   initial begin
      int           n;
      int           p0;
      int           bp_bad;
      logic [127:0] hold;

      reset     = 1'b1;
      not_empty = 1'b0;
      i_pull    = 1'b0;
      idata     = '0;
      repeat (2) @(negedge clk);
      check("rst_o_pop", {127'd0, o_pop}, 128'd0);
      check("rst_rdy",   {127'd0, rdy},   128'd0);
      check("rst_odata", odata,           128'd0);
      reset = 1'b0;
      @(negedge clk);

      // Single word: exact cycle-by-cycle latency.
      p0 = pop_cnt;
      push(64'hAAAA_0000_1111_2222);
      push(64'h3333_4444_5555_6666);
      check("t1_pop_c0", {127'd0, o_pop}, 128'd0);
      step(); check("t1_pop_c1", {127'd0, o_pop}, 128'd1);
      step(); check("t1_pop_c2", {127'd0, o_pop}, 128'd0);
      step(); check("t1_pop_c3", {127'd0, o_pop}, 128'd0);
      step(); check("t1_pop_c4", {127'd0, o_pop}, 128'd1);
      step(); check("t1_rdy_c5", {127'd0, rdy},   128'd0);
      step(); check("t1_rdy_c6", {127'd0, rdy},   128'd1);
      check("t1_odata", odata, 128'hAAAA0000111122223333444455556666);
      i_pull = 1'b1;
      step();
      i_pull = 1'b0;
      check("t1_rdy_c7",   {127'd0, rdy}, 128'd0);
      check("t1_odata_c7", odata, 128'hAAAA0000111122223333444455556666);
      check("t1_pops", pop_cnt - p0, 2);

      // Pop spacing: four words streamed with not_empty held high.
      p0 = pop_cnt;
      push(64'h0101_0101_0101_0101);
      push(64'h0202_0202_0202_0202);
      push(64'h0303_0303_0303_0303);
      push(64'h0404_0404_0404_0404);
      wait_rdy("t2_w0", n);
      check("t2_w0_odata", odata, 128'h01010101010101010202020202020202);
      check("t2_w0_pops", pop_cnt - p0, 2);
      i_pull = 1'b1; step(); i_pull = 1'b0;
      p0 = pop_cnt;
      wait_rdy("t2_w1", n);
      check("t2_w1_odata", odata, 128'h03030303030303030404040404040404);
      check("t2_w1_pops", pop_cnt - p0, 2);
      i_pull = 1'b1; step(); i_pull = 1'b0;

      // Underflow stall: second word arrives 20 cycles late.
      p0 = pop_cnt;
      push(64'hDEAD_BEEF_0000_0001);
      repeat (20) step();
      check("t3_stall_pops", pop_cnt - p0, 1);
      check("t3_stall_rdy", {127'd0, rdy}, 128'd0);
      push(64'hCAFE_F00D_0000_0002);
      wait_rdy("t3", n);
      check("t3_odata", odata, 128'hDEADBEEF00000001CAFEF00D00000002);
      check("t3_pops", pop_cnt - p0, 2);
      i_pull = 1'b1; step(); i_pull = 1'b0;

      // Consumer backpressure: held word with two more words waiting.
      p0 = pop_cnt;
      push(64'h1111_1111_1111_1111);
      push(64'h2222_2222_2222_2222);
      push(64'h5555_5555_5555_5555);
      push(64'h6666_6666_6666_6666);
      wait_rdy("t4_w0", n);
      hold   = odata;
      bp_bad = 0;
      repeat (50) begin
         step();
         if (!rdy || odata !== hold) bp_bad++;
      end
      check("t4_hold_odata", hold, 128'h11111111111111112222222222222222);
      check("t4_hold_bad", bp_bad, 0);
      check("t4_hold_pops", pop_cnt - p0, 2);
      i_pull = 1'b1; step(); i_pull = 1'b0;
      check("t4_rdy_fall", {127'd0, rdy},   128'd0);
      check("t4_pop_p1",   {127'd0, o_pop}, 128'd0);
      step();
      check("t4_pop_p2",   {127'd0, o_pop}, 128'd1);
      wait_rdy("t4_w1", n);
      check("t4_w1_odata", odata, 128'h55555555555555556666666666666666);
      i_pull = 1'b1; step(); i_pull = 1'b0;

      // Spurious pull held high through assembly.
      p0     = pop_cnt;
      i_pull = 1'b1;
      push(64'h7777_0000_0000_7777);
      push(64'h8888_0000_0000_8888);
      wait_rdy("t5", n);
      check("t5_latency", n, 6);
      check("t5_odata", odata, 128'h77770000000077778888000000008888);
      check("t5_pops", pop_cnt - p0, 2);
      step();
      i_pull = 1'b0;
      check("t5_rdy_after_pull", {127'd0, rdy}, 128'd0);

      // Reset mid-operation while a word is held and the FIFO is not empty.
      push(64'h9999_AAAA_BBBB_CCCC);
      push(64'hDDDD_EEEE_FFFF_0000);
      push(64'h1234_5678_9ABC_DEF0);
      wait_rdy("t6", n);
      check("t6_odata", odata, 128'h9999AAAABBBBCCCCDDDDEEEEFFFF0000);
      #2 reset = 1'b1;
      #1;
      check("t6_async_rdy",   {127'd0, rdy},   128'd0);
      check("t6_async_odata", odata,           128'd0);
      check("t6_async_pop",   {127'd0, o_pop}, 128'd0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t6_hold_pop", {127'd0, o_pop}, 128'd0);
         check("t6_hold_rdy", {127'd0, rdy},   128'd0);
      end
      fifo_q.delete();
      not_empty = 1'b0;
      reset     = 1'b0;
      step();

      // Recovery after reset.
      push(64'h0F0F_0F0F_0F0F_0F0F);
      push(64'hF0F0_F0F0_F0F0_F0F0);
      wait_rdy("t7", n);
      check("t7_latency", n, 6);
      check("t7_odata", odata, 128'h0F0F0F0F0F0F0F0FF0F0F0F0F0F0F0F0);
      i_pull = 1'b1; step(); i_pull = 1'b0;

      check("pop_adjacent", adj_cnt, 0);
      check("pop_underflow", under_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
